// File: rtl/req_onehot_sequencer_pkg.sv
// Shared types and helpers for the request one-hot sequencer.
// Ports: none (package). Provides NUM_REQ, IDX_W, pick_t and rr_pick().
// rr_pick is pure combinational; callers register its result as needed.
package req_onehot_sequencer_pkg;

  // Default number of request lines, which is also the encoder input width.
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = $clog2(NUM_REQ);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic               found;
    logic [IDX_W-1:0]   idx;
    logic [NUM_REQ-1:0] onehot;
  } pick_t;

  // Round-robin pick: scan pend starting at ptr, wrapping modulo NUM_REQ.
  // The first set bit wins; found=0 and onehot=0 when pend is empty.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] pend,
                                    input logic [IDX_W-1:0]   ptr);
    pick_t r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (int'(ptr) + i) % NUM_REQ;
      if (!r.found && pend[k]) begin
        r.found     = 1'b1;
        r.idx       = IDX_W'(k);
        r.onehot[k] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/req_onehot_sequencer_if.sv
// Output channel of the sequencer: one-hot grant with valid/ready handshake.
// Ports: onehot_out, out_valid (producer -> consumer), out_ready (consumer -> producer).
// master = sequencer side, slave = encoder / consumer side.
interface req_onehot_sequencer_if
  import req_onehot_sequencer_pkg::*;
#(
  parameter int N_REQ = NUM_REQ
);

  logic [N_REQ-1:0] onehot_out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output onehot_out,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  onehot_out,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/req_onehot_sequencer_sync_ff.sv
// 1-bit multi-flop synchroniser with asynchronous active-low clear.
// Ports: clk, rst_n, d (async input), q (synchronised output).
// Latency STAGES clocks; no backpressure.
module req_onehot_sequencer_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/req_onehot_sequencer.sv
// Captures rising edges on async request lines and issues them one at a time as a one-hot grant.
// Latency: req_in rise sampled at edge 1 -> pending at edge SYNC_STAGES+1 -> out_valid at SYNC_STAGES+2.
// Backpressure: grant held stable while out_ready=0; new edges keep accumulating in pending.
// Ports: clk, rst_n, req_in[N_REQ], out_if (master: onehot_out, out_valid, out_ready),
//        pending[N_REQ] (captured, not yet issued), overflow (1-cycle merge pulse).
module req_onehot_sequencer
  import req_onehot_sequencer_pkg::*;
#(
  parameter int N_REQ       = NUM_REQ,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_in,
  req_onehot_sequencer_if.master  out_if,
  output logic [N_REQ-1:0]        pending,
  output logic                    overflow
);

  // ------------------------------------------------------------------
  // Synchronisers and edge detect
  // ------------------------------------------------------------------
  logic [N_REQ-1:0] s;
  logic [N_REQ-1:0] s_d;
  logic [N_REQ-1:0] rise;

  for (genvar g = 0; g < N_REQ; g++) begin : g_sync
    req_onehot_sequencer_sync_ff #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (req_in[g]),
      .q     (s[g])
    );
  end

  // s_d clears on reset, so a line still high at release looks like a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d <= '0;
    end else begin
      s_d <= s;
    end
  end

  assign rise = s & ~s_d;

  // ------------------------------------------------------------------
  // Grant selection and FSM
  // ------------------------------------------------------------------
  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [N_REQ-1:0] onehot_q;
  pick_t            pick;
  logic             load;
  logic [N_REQ-1:0] load_mask;
  logic [N_REQ-1:0] pending_nxt;
  logic             overflow_nxt;
  logic [IDX_W-1:0] rr_ptr_nxt;

  assign pick = rr_pick(pending, rr_ptr);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_EMPTY: begin
        // out_ready has no meaning while nothing is presented.
        if (pick.found) begin
          load      = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_if.out_ready) begin
          if (pick.found) begin
            // Refill on the same edge as the accept: back-to-back, no bubble.
            load      = 1'b1;
            state_nxt = ST_FULL;
          end else begin
            state_nxt = ST_EMPTY;
          end
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase
  end

  always_comb begin
    load_mask    = load ? pick.onehot : '0;
    // A rise on the bit being loaded re-sets it: that is a genuinely new event.
    pending_nxt  = (pending & ~load_mask) | rise;
    // Edge landing on a line that stays pending merges into the existing event.
    overflow_nxt = |(rise & pending & ~load_mask);
    rr_ptr_nxt   = rr_ptr;
    if (load) begin
      rr_ptr_nxt = (pick.idx == IDX_W'(N_REQ - 1)) ? '0 : pick.idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      pending  <= '0;
      overflow <= 1'b0;
      rr_ptr   <= '0;
      onehot_q <= '0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      overflow <= overflow_nxt;
      rr_ptr   <= rr_ptr_nxt;
      if (load) begin
        onehot_q <= pick.onehot;
      end else if (state_nxt == ST_EMPTY) begin
        onehot_q <= '0;
      end
    end
  end

  // The state bit is the valid flag; onehot_q is zero whenever state is EMPTY.
  assign out_if.out_valid  = (state == ST_FULL);
  assign out_if.onehot_out = onehot_q;

endmodule

// File: tb/tb_req_onehot_sequencer.sv
module tb_req_onehot_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_in;
  logic [3:0] pending;
  logic       overflow;

  always #5 clk = ~clk;

  req_onehot_sequencer_if #(.N_REQ(4)) ch ();

  req_onehot_sequencer #(
    .N_REQ       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .out_if   (ch),
    .pending  (pending),
    .overflow (overflow)
  );

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  int log_idx[$];
  int log_cyc[$];

  typedef struct packed {
    logic [3:0] req;
    logic [2:0] n;
    logic [7:0] seq;   // issue order, 2 bits per index, first in [1:0]
  } vec_t;

  vec_t tbl [7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Reference 4:2 encoder that the sequencer feeds.
  function automatic int enc42(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle one-hot invariant plus log of accepted grants through the encoder.
  always @(negedge clk) begin
    int ones;
    ones = $countones(ch.onehot_out);
    check("onehot_invariant", ones, ch.out_valid ? 1 : 0);
    if (ch.out_valid === 1'b1 && ch.out_ready === 1'b1) begin
      log_idx.push_back(enc42(ch.onehot_out));
      log_cyc.push_back(cyc);
    end
  end

  initial begin
    int start;
    int ovf_cnt;
    int n3;

    tbl[0] = '{req: 4'b1000, n: 3'd1, seq: 8'h03};  // restores rr_ptr to 0
    tbl[1] = '{req: 4'b1011, n: 3'd3, seq: 8'h34};  // 0,1,3
    tbl[2] = '{req: 4'b0001, n: 3'd1, seq: 8'h00};  // rr_ptr wrapped to 0
    tbl[3] = '{req: 4'b0100, n: 3'd1, seq: 8'h02};
    tbl[4] = '{req: 4'b0111, n: 3'd3, seq: 8'h24};  // from ptr 3: 0,1,2
    tbl[5] = '{req: 4'b1010, n: 3'd2, seq: 8'h07};  // from ptr 3: 3,1
    tbl[6] = '{req: 4'b1111, n: 3'd4, seq: 8'h4E};  // from ptr 2: 2,3,0,1

    // ---------------- Test 1: reset with all lines high ----------------
    rst_n        = 1'b0;
    req_in       = 4'b1111;
    ch.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_onehot", int'(ch.onehot_out), 0);
    check("rst_valid", int'(ch.out_valid), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_overflow", int'(overflow), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("t1_pending_e2", int'(pending), 0);
    tick();
    check("t1_pending_e3", int'(pending), 4'b1111);
    check("t1_valid_e3", int'(ch.out_valid), 0);
    tick();
    check("t1_valid_e4", int'(ch.out_valid), 1);
    check("t1_onehot_e4", int'(ch.onehot_out), 4'b0001);
    check("t1_pending_e4", int'(pending), 4'b1110);
    log_idx.delete(); log_cyc.delete();
    ch.out_ready = 1'b1;
    repeat (6) tick();
    check("t1_drain_n", log_idx.size(), 4);
    for (int j = 0; j < 4; j++) begin
      if (j < log_idx.size()) begin
        check("t1_drain_idx", log_idx[j], j);
        check("t1_drain_cyc", log_cyc[j] - log_cyc[0], j);
      end
    end

    // ---------------- Test 2: single event, exact latency ----------------
    req_in = 4'b0000;
    repeat (4) tick();
    log_idx.delete(); log_cyc.delete();
    req_in = 4'b0100;
    repeat (3) tick();
    check("t2_pending_e3", int'(pending), 4'b0100);
    check("t2_valid_e3", int'(ch.out_valid), 0);
    tick();
    check("t2_onehot_e4", int'(ch.onehot_out), 4'b0100);
    check("t2_valid_e4", int'(ch.out_valid), 1);
    check("t2_pending_e4", int'(pending), 0);
    tick();
    check("t2_valid_e5", int'(ch.out_valid), 0);
    check("t2_onehot_e5", int'(ch.onehot_out), 0);
    check("t2_issue_n", log_idx.size(), 1);

    // ---------------- Table: simultaneous edges, round-robin order ----------------
    for (int i = 0; i < 7; i++) begin
      req_in       = 4'b0000;
      ch.out_ready = 1'b1;
      repeat (4) tick();
      log_idx.delete(); log_cyc.delete();
      req_in = tbl[i].req;
      start  = cyc;
      repeat (10) tick();
      check($sformatf("vec%0d_n", i), log_idx.size(), int'(tbl[i].n));
      for (int j = 0; j < int'(tbl[i].n); j++) begin
        if (j < log_idx.size()) begin
          check($sformatf("vec%0d_idx%0d", i, j), log_idx[j], int'(tbl[i].seq[2*j +: 2]));
          check($sformatf("vec%0d_cyc%0d", i, j), log_cyc[j], start + 4 + j);
        end
      end
      check($sformatf("vec%0d_pending", i), int'(pending), 0);
      check($sformatf("vec%0d_valid", i), int'(ch.out_valid), 0);
    end

    // ---------------- Test 4: backpressure ----------------
    req_in = 4'b0000;
    repeat (4) tick();
    ch.out_ready = 1'b0;
    req_in       = 4'b0010;           // rr_ptr=2 -> picks line 1
    repeat (4) tick();
    check("t4_valid", int'(ch.out_valid), 1);
    check("t4_onehot", int'(ch.onehot_out), 4'b0010);
    req_in = 4'b0110;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t4_stall_onehot", int'(ch.onehot_out), 4'b0010);
      check("t4_stall_valid", int'(ch.out_valid), 1);
    end
    check("t4_pending", int'(pending), 4'b0100);
    log_idx.delete(); log_cyc.delete();
    ch.out_ready = 1'b1;
    tick();
    check("t4_nogap_onehot", int'(ch.onehot_out), 4'b0100);
    check("t4_nogap_valid", int'(ch.out_valid), 1);
    tick();
    check("t4_done_valid", int'(ch.out_valid), 0);
    check("t4_issue_n", log_idx.size(), 2);
    if (log_idx.size() == 2) begin
      check("t4_issue0", log_idx[0], 1);
      check("t4_issue1", log_idx[1], 2);
      check("t4_issue_gap", log_cyc[1] - log_cyc[0], 1);
    end

    // ---------------- Test 5: overflow merge ----------------
    req_in = 4'b0000;
    repeat (5) tick();
    ch.out_ready = 1'b0;
    req_in       = 4'b0001;           // rr_ptr=3 -> line 0 taken, stalls
    repeat (5) tick();
    req_in = 4'b1001;
    repeat (5) tick();
    check("t5_pending", int'(pending), 4'b1000);
    check("t5_onehot", int'(ch.onehot_out), 4'b0001);
    req_in = 4'b0001;
    ovf_cnt = 0;
    repeat (2) begin
      tick();
      ovf_cnt += int'(overflow);
    end
    req_in = 4'b1001;
    repeat (6) begin
      tick();
      ovf_cnt += int'(overflow);
    end
    check("t5_overflow_pulses", ovf_cnt, 1);
    check("t5_pending_merged", int'(pending), 4'b1000);
    log_idx.delete(); log_cyc.delete();
    ch.out_ready = 1'b1;
    repeat (4) tick();
    n3 = 0;
    foreach (log_idx[j]) if (log_idx[j] == 3) n3++;
    check("t5_issue_n", log_idx.size(), 2);
    check("t5_line3_once", n3, 1);

    // ---------------- Test 6: async reset mid-FULL ----------------
    req_in = 4'b0000;
    repeat (4) tick();
    ch.out_ready = 1'b0;
    req_in       = 4'b0001;
    repeat (4) tick();
    req_in = 4'b0111;
    repeat (4) tick();
    check("t6_pre_valid", int'(ch.out_valid), 1);
    check("t6_pre_pending", int'(pending), 4'b0110);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_onehot", int'(ch.onehot_out), 0);
    check("t6_async_valid", int'(ch.out_valid), 0);
    check("t6_async_pending", int'(pending), 0);
    check("t6_async_overflow", int'(overflow), 0);
    req_in = 4'b0000;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("t6_post_pending", int'(pending), 0);
    check("t6_post_valid", int'(ch.out_valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
